fifo_single_clock_reg_v3: RTL and testbench

Single-clock register-based FIFO; circular-buffer successor to the shift-register FIFO family.
- DEPTH is any integer ≥ 2; it does not have to be a power of 2.
- Adds programmable almost-full and almost-empty flags.
- Supports a true simultaneous read and write when the FIFO is full.
- In normal (non-FWFT) mode, a registered output carries an r_valid strobe.
- Used as a generic elastic buffer between streaming stages.

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_ptr_wrap.sv | 18 +
 rtl/fifo_single_clock_reg_v3.sv | 99 +++++++++
 tb/tb_fifo_single_clock_reg_v3.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and mode constants for the register FIFO family.
package fifo_pkg;
    localparam string FWFT_TRUE = "TRUE";
    localparam string FWFT_FALSE = "FALSE";
    function automatic int clogb2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic bit in_range(input int v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction
endpackage

// File: rtl/fifo_ptr_wrap.sv
// fifo_ptr_wrap: circular pointer that wraps from DEPTH-1 back to 0 on inc.
module fifo_ptr_wrap
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32,
    localparam int PW = clogb2(DEPTH)
) (
    input  logic          clk,
    input  logic          nrst,
    input  logic          inc,
    output logic [PW-1:0] ptr
);
    logic [PW-1:0] ptr_q, ptr_d;
    // explicit compare so non-power-of-2 depths wrap correctly
    assign ptr_d = !inc ? ptr_q : (ptr_q == PW'(DEPTH - 1) ? '0 : ptr_q + 1'b1);
    always_ff @(posedge clk) ptr_q <= nrst ? ptr_d : '0;
    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_single_clock_reg_v3.sv
// fifo_single_clock_reg_v3: circular-buffer FIFO with FWFT/normal output and almost flags.
// Define FIFO_SINGLE_CLOCK_REG_V3_STATS_EN to enable the max_cnt / err_sticky statistics.
module fifo_single_clock_reg_v3
    import fifo_pkg::*;
#(
    parameter string FWFT_MODE  = FWFT_TRUE,
    parameter int    DEPTH      = 32,
    parameter int    DEPTH_W    = clogb2(DEPTH) + 1,
    parameter int    DATA_W     = 32,
    parameter int    AFULL_LVL  = DEPTH - 1,
    parameter int    AEMPTY_LVL = 1
) (
    input  logic               clk,
    input  logic               nrst,
    input  logic               w_req,
    input  logic [DATA_W-1:0]  w_data,
    input  logic               r_req,
    output logic [DATA_W-1:0]  r_data,
    output logic               r_valid,
    output logic [DEPTH_W-1:0] cnt,
    output logic               empty,
    output logic               full,
    output logic               afull,
    output logic               aempty,
    output logic               fail,
    output logic [DEPTH_W-1:0] max_cnt,
    output logic               err_sticky
);
    localparam int PW = clogb2(DEPTH);

    if (DEPTH < 2) begin : g_bad_depth
        $error("DEPTH must be at least 2");
    end
    if (DEPTH >= (1 << DEPTH_W)) begin : g_bad_depth_w
        $error("DEPTH_W too narrow to hold DEPTH");
    end
    if (!in_range(AFULL_LVL, 1, DEPTH)) begin : g_bad_afull
        $error("AFULL_LVL out of range 1..DEPTH");
    end
    if (!in_range(AEMPTY_LVL, 0, DEPTH - 1)) begin : g_bad_aempty
        $error("AEMPTY_LVL out of range 0..DEPTH-1");
    end

    logic [DATA_W-1:0]  mem_q [DEPTH];
    logic [PW-1:0]      w_ptr, r_ptr;
    logic [DEPTH_W-1:0] cnt_q, cnt_d;
    logic               rd_ok, wr_ok;

    assign empty  = cnt_q == '0;
    assign full   = cnt_q == DEPTH_W'(DEPTH);
    assign afull  = cnt_q >= DEPTH_W'(AFULL_LVL);
    assign aempty = cnt_q <= DEPTH_W'(AEMPTY_LVL);
    assign cnt    = cnt_q;
    assign fail   = (r_req & empty) | (w_req & full & ~r_req);
    // a read frees the slot, so a full FIFO still takes a concurrent write
    assign rd_ok  = nrst & r_req & ~empty;
    assign wr_ok  = nrst & w_req & (~full | r_req);
    assign cnt_d  = cnt_q + DEPTH_W'(wr_ok) - DEPTH_W'(rd_ok);

    always_ff @(posedge clk) cnt_q <= nrst ? cnt_d : '0;
    always_ff @(posedge clk) if (wr_ok) mem_q[w_ptr] <= w_data;

    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_w_ptr (.clk(clk), .nrst(nrst), .inc(wr_ok), .ptr(w_ptr));
    fifo_ptr_wrap #(.DEPTH(DEPTH)) u_r_ptr (.clk(clk), .nrst(nrst), .inc(rd_ok), .ptr(r_ptr));

    if (FWFT_MODE == FWFT_TRUE) begin : g_fwft
        assign r_data  = empty ? '0 : mem_q[r_ptr];
        assign r_valid = ~empty;
    end else begin : g_normal
        logic [DATA_W-1:0] r_data_q;
        logic              r_valid_q;
        always_ff @(posedge clk) begin
            r_valid_q <= rd_ok;
            if (!nrst) r_data_q <= '0;
            else if (rd_ok) r_data_q <= mem_q[r_ptr];
        end
        assign r_data  = r_data_q;
        assign r_valid = r_valid_q;
    end

`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
    logic [DEPTH_W-1:0] max_cnt_q;
    logic               err_q;
    always_ff @(posedge clk) begin
        if (!nrst) begin
            max_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (cnt_d > max_cnt_q) max_cnt_q <= cnt_d;
            if (fail) err_q <= 1'b1;
        end
    end
    assign max_cnt    = max_cnt_q;
    assign err_sticky = err_q;
`else
    assign max_cnt    = '0;
    assign err_sticky = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_single_clock_reg_v3.sv
// tb_fifo_single_clock_reg_v3: scoreboard bench driving an FWFT and a normal-mode FIFO side by side.
module tb_fifo_single_clock_reg_v3;
    localparam int DEPTH = 5, DW = 8, CW = 4, AF = 4, AE = 1;
`ifdef FIFO_SINGLE_CLOCK_REG_V3_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0, nrst = 1'b0, w_req = 1'b0, r_req = 1'b0;
    logic [DW-1:0] w_data = '0;
    logic [DW-1:0] rd_f, rd_n;
    logic [CW-1:0] cnt_f, cnt_n, mx_f, mx_n;
    logic rv_f, rv_n, em_f, em_n, fu_f, fu_n, af_f, af_n, ae_f, ae_n, fl_f, fl_n, es_f, es_n;

    always #5 clk = ~clk;

    fifo_single_clock_reg_v3 #(.FWFT_MODE("TRUE"), .DEPTH(DEPTH), .DEPTH_W(CW), .DATA_W(DW),
        .AFULL_LVL(AF), .AEMPTY_LVL(AE)) u_fwft (
        .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(rd_f), .r_valid(rv_f), .cnt(cnt_f), .empty(em_f), .full(fu_f),
        .afull(af_f), .aempty(ae_f), .fail(fl_f), .max_cnt(mx_f), .err_sticky(es_f));

    fifo_single_clock_reg_v3 #(.FWFT_MODE("FALSE"), .DEPTH(DEPTH), .DEPTH_W(CW), .DATA_W(DW),
        .AFULL_LVL(AF), .AEMPTY_LVL(AE)) u_norm (
        .clk(clk), .nrst(nrst), .w_req(w_req), .w_data(w_data), .r_req(r_req),
        .r_data(rd_n), .r_valid(rv_n), .cnt(cnt_n), .empty(em_n), .full(fu_n),
        .afull(af_n), .aempty(ae_n), .fail(fl_n), .max_cnt(mx_n), .err_sticky(es_n));

    // reference model: a plain queue of stored words plus running stats
    logic [DW-1:0] mq[$], sb_f[$], sb_n[$];
    logic [DW-1:0] last_n = '0;
    int  checks = 0, errors = 0;
    int  e_cnt = 0, e_max = 0, max_acc = 0;
    bit  e_fail = 0, e_nvalid = 0, e_err = 0, err_acc = 0, pend_rd = 0, chk = 0;

    task automatic ck(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask

    task automatic ck_dut(input string t, input logic [CW-1:0] c, input logic em, input logic fu,
                          input logic af, input logic ae, input logic fl, input logic [CW-1:0] mx,
                          input logic es);
        ck({t, "_cnt"}, c, e_cnt);
        ck({t, "_empty"}, em, e_cnt == 0);
        ck({t, "_full"}, fu, e_cnt == DEPTH);
        ck({t, "_afull"}, af, e_cnt >= AF);
        ck({t, "_aempty"}, ae, e_cnt <= AE);
        ck({t, "_fail"}, fl, e_fail);
        ck({t, "_max_cnt"}, mx, STATS ? e_max : 0);
        ck({t, "_err_sticky"}, es, STATS ? e_err : 1'b0);
    endtask

    task automatic cyc(input bit rst_n, input bit w, input bit r, input logic [DW-1:0] d);
        bit rd, wr;
        @(posedge clk);
        #1;
        nrst = rst_n; w_req = w; r_req = r; w_data = d;
        chk = rst_n;
        e_nvalid = pend_rd;
        e_cnt = mq.size();
        if (e_cnt > max_acc) max_acc = e_cnt;
        e_max = max_acc;
        e_err = err_acc;
        e_fail = (r && e_cnt == 0) || (w && e_cnt == DEPTH && !r);
        rd = rst_n && r && e_cnt > 0;
        wr = rst_n && w && (e_cnt < DEPTH || r);
        if (rd) begin
            sb_f.push_back(mq[0]);
            sb_n.push_back(mq[0]);
            void'(mq.pop_front());
        end
        if (wr) mq.push_back(d);
        err_acc = err_acc | e_fail;
        pend_rd = rd;
        if (!rst_n) begin
            mq.delete(); sb_f.delete(); sb_n.delete();
            max_acc = 0; err_acc = 0; pend_rd = 0;
        end
    endtask

    task automatic wr_w(input logic [DW-1:0] d); cyc(1, 1, 0, d); endtask
    task automatic rd_w(); cyc(1, 0, 1, '0); endtask

    always @(negedge clk) begin
        logic [DW-1:0] exp;
        if (chk) begin
            ck_dut("fwft", cnt_f, em_f, fu_f, af_f, ae_f, fl_f, mx_f, es_f);
            ck_dut("norm", cnt_n, em_n, fu_n, af_n, ae_n, fl_n, mx_n, es_n);
            ck("fwft_r_valid", rv_f, e_cnt != 0);
            if (!rv_f) ck("fwft_r_data_empty", rd_f, 0);
            else if (r_req) begin
                if (sb_f.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL fwft_sb_underflow got read want none at %0t", $time);
                end else ck("fwft_r_data", rd_f, sb_f.pop_front());
            end
            ck("norm_r_valid", rv_n, e_nvalid);
            if (rv_n) begin
                if (sb_n.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL norm_sb_underflow got r_valid want none at %0t", $time);
                end else begin
                    exp = sb_n.pop_front();
                    ck("norm_r_data", rd_n, exp);
                    last_n = exp;
                end
            end else ck("norm_r_data_hold", rd_n, last_n);
        end else if (!nrst) last_n = '0;
    end

    initial begin
        int wp, rp;
        cyc(0, 1, 1, 8'h99);
        cyc(0, 0, 0, '0);
        for (int i = 0; i < 5; i++) wr_w(8'h11 + DW'(i));
        for (int i = 0; i < 3; i++) rd_w();
        for (int i = 0; i < 3; i++) wr_w(8'h16 + DW'(i));
        cyc(1, 1, 0, 8'hEE);
        for (int i = 0; i < 5; i++) rd_w();
        rd_w();
        for (int i = 0; i < 5; i++) wr_w(8'h11 + DW'(i));
        cyc(1, 1, 1, 8'hAA);
        cyc(1, 1, 0, 8'hEF);
        for (int i = 0; i < 6; i++) rd_w();
        cyc(1, 1, 1, 8'h55);
        rd_w();
        cyc(1, 0, 0, '0);
        wr_w(8'h21); wr_w(8'h22); rd_w();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        wp = 50; rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                wp = $urandom_range(10, 90);
                rp = $urandom_range(10, 90);
            end
            cyc(i != 1500, $urandom_range(0, 99) < wp, $urandom_range(0, 99) < rp, DW'($urandom));
        end
        for (int i = 0; i < 8; i++) rd_w();
        cyc(1, 0, 0, '0);
        cyc(1, 0, 0, '0);
        @(posedge clk);
        chk = 0;
        ck("sb_drained", sb_f.size() + sb_n.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
